// File: rtl/ret_addr_stack_pkg.sv
// Shared return-stack types: default sizing, checkpoint layout and jump-decoder constants.
// Consumers tag branches with ras_ckpt_t when built at the default depth.
package ret_addr_stack_pkg;

  localparam int RAS_DEPTH_DEF    = 16;
  localparam int RAS_IP_WIDTH_DEF = 64;
  localparam int RAS_PTR_W_DEF    = $clog2(RAS_DEPTH_DEF);

  // Snapshot layout {count-nonzero, top index}.
  typedef struct packed {
    logic                     nz;
    logic [RAS_PTR_W_DEF-1:0] idx;
  } ras_ckpt_t;

  // Jump-decoder opcodes that produce push/pop strobes.
  localparam logic [7:0] OP_CALL_REL32  = 8'hE8;
  localparam logic [7:0] OP_RET_NEAR    = 8'hC3;
  localparam logic [7:0] OP_RET_IMM16   = 8'hC2;
  localparam logic [7:0] OP_GRP5        = 8'hFF;
  localparam logic [2:0] MODRM_CALL_IND = 3'd2;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_CALL = 2'd1,
    JMP_RET  = 2'd2,
    JMP_TAIL = 2'd3
  } jmp_kind_e;

  function automatic jmp_kind_e ras_jmp_kind(input logic push, input logic pop);
    jmp_kind_e k;
    k = JMP_NONE;
    if (push && pop) k = JMP_TAIL;
    else if (push)   k = JMP_CALL;
    else if (pop)    k = JMP_RET;
    return k;
  endfunction

endpackage

// File: rtl/ret_addr_stack_ram.sv
// Return-address storage: one write port, one asynchronous read port, no reset.
// Write lands on the rising edge; read data follows raddr_i combinationally.
module ras_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular return-address stack; push/pop visible on predAddr one cycle later, never stalls.
// RAS_REPAIR_EN enables checkpoint output and mispredict restore (otherwise restore is ignored).
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int DEPTH    = RAS_DEPTH_DEF,
  parameter int IP_WIDTH = RAS_IP_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pushCallStack,
  input  logic                     popCallStack,
  input  logic [IP_WIDTH-1:0]      retAddr,
  output logic [IP_WIDTH-1:0]      predAddr,
  output logic                     predValid,
  output logic [$clog2(DEPTH):0]   ckptPtr,
  input  logic                     restore,
  input  logic [$clog2(DEPTH):0]   restorePtr,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0] tp_q, tp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          underflow_q, underflow_d;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic          empty;
  jmp_kind_e     kind;

  assign empty = (cnt_q == '0);

  always_comb begin
    tp_d        = tp_q;
    cnt_d       = cnt_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = tp_q;
    kind        = ras_jmp_kind(pushCallStack, popCallStack);
    // A tail call on an empty stack has nothing to replace, so it becomes a plain call.
    if (kind == JMP_TAIL && empty) kind = JMP_CALL;

    case (kind)
      JMP_CALL: begin
        tp_d   = tp_q + PW'(1);
        wr_en  = 1'b1;
        wr_idx = tp_q + PW'(1);
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
      end
      JMP_RET: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          tp_d  = tp_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end
      JMP_TAIL: begin
        wr_en  = 1'b1;
        wr_idx = tp_q;
      end
      default: ;
    endcase

`ifdef RAS_REPAIR_EN
    if (restore) begin
      wr_en       = 1'b0;
      underflow_d = 1'b0;
      tp_d        = restorePtr[PW-1:0];
      cnt_d       = restorePtr[PW] ? CW'(1) : '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_q        <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  ras_ram #(
    .DEPTH (DEPTH),
    .WIDTH (IP_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_idx),
    .wdata_i (retAddr),
    .raddr_i (tp_q),
    .rdata_o (predAddr)
  );

  assign predValid = !empty;
  assign underflow = underflow_q;

`ifdef RAS_REPAIR_EN
  typedef struct packed {
    logic          nz;
    logic [PW-1:0] idx;
  } ckpt_t;

  ckpt_t ckpt;
  assign ckpt    = '{nz: !empty, idx: tp_q};
  assign ckptPtr = ckpt;
`else
  logic unused_restore;
  assign unused_restore = ^{restore, restorePtr};
  assign ckptPtr        = '0;
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack at DEPTH=16, IP_WIDTH=64 (both RAS_REPAIR_EN builds).
module tb_ret_addr_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic        pop;
  logic [63:0] ret_addr;
  logic [63:0] pred_addr;
  logic        pred_valid;
  logic [4:0]  ckpt_ptr;
  logic        restore;
  logic [4:0]  restore_ptr;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  logic [4:0] ck;

  always #5 clk = ~clk;

  ret_addr_stack #(.DEPTH(16), .IP_WIDTH(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .pushCallStack (push),
    .popCallStack  (pop),
    .retAddr       (ret_addr),
    .predAddr      (pred_addr),
    .predValid     (pred_valid),
    .ckptPtr       (ckpt_ptr),
    .restore       (restore),
    .restorePtr    (restore_ptr),
    .underflow     (underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; returns 1ns after the edge.
  task automatic cyc(input logic pu, input logic po, input logic [63:0] a);
    push     = pu;
    pop      = po;
    ret_addr = a;
    @(posedge clk);
    #1;
    push     = 1'b0;
    pop      = 1'b0;
    ret_addr = '0;
  endtask

  initial begin
    rst         = 1'b1;
    push        = 1'b0;
    pop         = 1'b0;
    ret_addr    = '0;
    restore     = 1'b0;
    restore_ptr = '0;
    #1;
    chk("rst_pred_valid", 64'(pred_valid), 64'd0);
    chk("rst_underflow",  64'(underflow),  64'd0);
    chk("rst_ckpt",       64'(ckpt_ptr),   64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // push 0x1000, 0x2000, pop
    cyc(1, 0, 64'h1000);
    chk("push1_pred", pred_addr, 64'h1000);
    chk("push1_valid", 64'(pred_valid), 64'd1);
    cyc(1, 0, 64'h2000);
    chk("push2_pred", pred_addr, 64'h2000);
    chk("push2_cnt", 64'(dut.cnt_q), 64'd2);
    cyc(0, 1, '0);
    chk("pop_pred", pred_addr, 64'h1000);
    chk("pop_valid", 64'(pred_valid), 64'd1);
    chk("pop_cnt", 64'(dut.cnt_q), 64'd1);

    // drain, then pop on empty
    cyc(0, 1, '0);
    chk("drain_valid", 64'(pred_valid), 64'd0);
    chk("drain_tp", 64'(dut.tp_q), 64'd0);
    chk("pre_uf", 64'(underflow), 64'd0);
    cyc(0, 1, '0);
    chk("uf_pulse", 64'(underflow), 64'd1);
    chk("uf_tp", 64'(dut.tp_q), 64'd0);
    chk("uf_cnt", 64'(dut.cnt_q), 64'd0);
    cyc(0, 0, '0);
    chk("uf_drop", 64'(underflow), 64'd0);

    // tail call over top 0x3000
    cyc(1, 0, 64'h3000);
    chk("tail_pre_pred", pred_addr, 64'h3000);
    cyc(1, 1, 64'h4000);
    chk("tail_pred", pred_addr, 64'h4000);
    chk("tail_cnt", 64'(dut.cnt_q), 64'd1);
    chk("tail_tp", 64'(dut.tp_q), 64'd1);
    chk("tail_uf", 64'(underflow), 64'd0);

    // tail call on empty acts as push
    cyc(0, 1, '0);
    cyc(1, 1, 64'h5000);
    chk("tail_empty_pred", pred_addr, 64'h5000);
    chk("tail_empty_cnt", 64'(dut.cnt_q), 64'd1);
    chk("tail_empty_tp", 64'(dut.tp_q), 64'd1);
    chk("tail_empty_uf", 64'(underflow), 64'd0);
    cyc(0, 1, '0);
    chk("tail_empty_drain", 64'(pred_valid), 64'd0);

    // 17 pushes wrap over the oldest entry
    for (int i = 0; i < 17; i++) cyc(1, 0, 64'h10 + 64'(i));
    chk("wrap_cnt", 64'(dut.cnt_q), 64'd16);
    chk("wrap_pred", pred_addr, 64'h20);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("wrap_pop%0d", k), pred_addr, 64'h20 - 64'(k));
      chk($sformatf("wrap_valid%0d", k), 64'(pred_valid), 64'd1);
      cyc(0, 1, '0);
    end
    chk("wrap_empty", 64'(pred_valid), 64'd0);
    chk("wrap_tp", 64'(dut.tp_q), 64'd1);

    // checkpoint / restore (tp=1, cnt=0 here)
    cyc(1, 0, 64'hA000);
`ifdef RAS_REPAIR_EN
    chk("ckpt_capture", 64'(ckpt_ptr), 64'h12);
`else
    chk("ckpt_zero", 64'(ckpt_ptr), 64'h0);
`endif
    ck = ckpt_ptr;
    cyc(1, 0, 64'hB000);
    cyc(1, 0, 64'hC000);
    cyc(1, 0, 64'hD000);
    chk("ckpt_depth", 64'(dut.cnt_q), 64'd4);
    restore = 1'b1;
`ifdef RAS_REPAIR_EN
    restore_ptr = ck;
`else
    restore_ptr = 5'h1F;
`endif
    cyc(1, 1, 64'hE000);
    restore     = 1'b0;
    restore_ptr = '0;
`ifdef RAS_REPAIR_EN
    chk("restore_tp", 64'(dut.tp_q), 64'd2);
    chk("restore_cnt", 64'(dut.cnt_q), 64'd1);
    chk("restore_pred", pred_addr, 64'hA000);
    chk("restore_ckpt", 64'(ckpt_ptr), 64'h12);
`else
    chk("norestore_tp", 64'(dut.tp_q), 64'd5);
    chk("norestore_cnt", 64'(dut.cnt_q), 64'd4);
    chk("norestore_pred", pred_addr, 64'hE000);
    chk("norestore_ckpt", 64'(ckpt_ptr), 64'h0);
`endif

    // async reset mid-sequence with cnt=5
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 0, 64'h100 + 64'(i));
    chk("pre_rst_cnt", 64'(dut.cnt_q), 64'd5);
    chk("pre_rst_valid", 64'(pred_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(pred_valid), 64'd0);
    chk("async_rst_cnt", 64'(dut.cnt_q), 64'd0);
    chk("async_rst_ckpt", 64'(ckpt_ptr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 64'h9000);
    chk("post_rst_pred", pred_addr, 64'h9000);
    chk("post_rst_valid", 64'(pred_valid), 64'd1);
    chk("post_rst_cnt", 64'(dut.cnt_q), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
